// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp channel state and default widths used by the
// pwm compare path and the ramp sequencer.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } chan_state_e;

  localparam int DEF_NCH       = 4;
  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_IVL_WIDTH = 16;

endpackage

// File: rtl/pwm_ramp_chan.sv
// One ramp channel: immediate load or timed, target-saturating compare ramp.
module pwm_ramp_chan
  import pwm_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int IVL_WIDTH = DEF_IVL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 accept_i,
  input  logic [PWM_BITS-1:0]  target_i,
  input  logic [PWM_BITS-1:0]  step_i,
  input  logic [IVL_WIDTH-1:0] interval_i,
  output logic [PWM_BITS-1:0]  compare_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 enable_o
);

  chan_state_e          state_q;
  logic [PWM_BITS-1:0]  cmp_q, tgt_q, step_q;
  logic [IVL_WIDTH-1:0] ivl_q, cnt_q;
  logic                 done_q;

  logic [PWM_BITS:0]    up_sum;
  logic [PWM_BITS-1:0]  dn_gap;
  logic [PWM_BITS-1:0]  cmp_step_d;

  // Clamp each step at the target so the compare never overshoots or wraps.
  always_comb begin
    up_sum = {1'b0, cmp_q} + {1'b0, step_q};
    dn_gap = cmp_q - tgt_q;
    cmp_step_d = tgt_q;
    if (tgt_q > cmp_q) begin
      if (up_sum < {1'b0, tgt_q}) cmp_step_d = up_sum[PWM_BITS-1:0];
    end else begin
      if (step_q < dn_gap) cmp_step_d = cmp_q - step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmp_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      ivl_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_i) begin
            if (step_i == '0 || target_i == cmp_q) begin
              cmp_q  <= target_i;
              done_q <= 1'b1;
            end else begin
              state_q <= RAMP;
              tgt_q   <= target_i;
              step_q  <= step_i;
              ivl_q   <= interval_i;
              cnt_q   <= '0;
            end
          end
        end
        RAMP: begin
          if (cnt_q == ivl_q) begin
            cnt_q <= '0;
            cmp_q <= cmp_step_d;
            if (cmp_step_d == tgt_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign compare_o = cmp_q;
  assign busy_o    = (state_q == RAMP);
  assign done_o    = done_q;
  assign enable_o  = (cmp_q != '0) || busy_o;

endmodule

// File: rtl/pwm_ramp_seq.sv
// Multi-channel PWM compare ramp sequencer. Define PWM_RAMP_SEQ_IRQ_EN to add
// sticky per-channel done status with irq_o / irq_clr (write-one-to-clear).
module pwm_ramp_seq
  import pwm_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int IVL_WIDTH = DEF_IVL_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(NCH)-1:0]  cmd_ch,
  input  logic [PWM_BITS-1:0]     cmd_target,
  input  logic [PWM_BITS-1:0]     cmd_step,
  input  logic [IVL_WIDTH-1:0]    cmd_interval,
`ifdef PWM_RAMP_SEQ_IRQ_EN
  output logic                    irq_o,
  input  logic [NCH-1:0]          irq_clr,
`endif
  output logic [NCH*PWM_BITS-1:0] compare_o,
  output logic [NCH-1:0]          enable_o,
  output logic [NCH-1:0]          busy_o,
  output logic [NCH-1:0]          done_o
);

  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] accept;

  // An out-of-range channel matches no lane, so it is never ready.
  always_comb begin
    cmd_ready = 1'b0;
    accept    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == CHW'(i)) cmd_ready = ~busy_o[i];
    end
    for (int i = 0; i < NCH; i++) begin
      accept[i] = cmd_valid && cmd_ready && (cmd_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pwm_ramp_chan #(
      .PWM_BITS  (PWM_BITS),
      .IVL_WIDTH (IVL_WIDTH)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .accept_i   (accept[g]),
      .target_i   (cmd_target),
      .step_i     (cmd_step),
      .interval_i (cmd_interval),
      .compare_o  (compare_o[g*PWM_BITS +: PWM_BITS]),
      .busy_o     (busy_o[g]),
      .done_o     (done_o[g]),
      .enable_o   (enable_o[g])
    );
  end

`ifdef PWM_RAMP_SEQ_IRQ_EN
  logic [NCH-1:0] status_q, status_d;

  // A done pulse beats a same-cycle clear of the same bit.
  assign status_d = (status_q & ~irq_clr) | done_o;

  always_ff @(posedge clk) begin
    if (reset) status_q <= '0;
    else       status_q <= status_d;
  end

  assign irq_o = |status_q;
`endif

endmodule
